// File: rtl/wb_cmd_master_pkg.sv
// Shared types and defaults for the Wishbone command master.
// FSM state encoding, default bus widths, counter width helper.
package wb_cmd_master_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int cnt_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone signal bundle for wb_cmd_master.
// master: the initiator's view; slave: the environment's view.
interface wb_cmd_master_if
  import wb_cmd_master_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [DW/8-1:0] cmd_sel_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;

  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;

  logic          busy_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_sel_i,
    input  cmd_adr_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i,
    output busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_sel_i,
    output cmd_adr_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i,
    input  busy_o
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Saturating wait-cycle counter for a pending Wishbone cycle.
// clk_i/rst_ni; clr_i zeroes, en_i counts; expired_o = count hits TIMEOUT.
module wb_timeout_ctr
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Compare the value being loaded this edge so the
  // owner can abort on the same edge the limit is hit.
  assign expired_o = (cnt_d == LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one WB cycle, one response.
// wb_clk_i, wb_rst_i (async, active-low); bus carries cmd/rsp/wbm signals.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wb_cmd_master_if.master bus
);

  localparam int SW = DW / 8;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          rv_q, rv_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          re_q, re_d;

  logic accept;
  logic expired;
  logic tmo_en;

  assign accept = (state_q == ST_IDLE) && bus.cmd_valid_i;
  assign tmo_en = (state_q == ST_BUS) && !bus.wbm_ack_i;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_i),
    .clr_i     (accept),
    .en_i      (tmo_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    re_d    = re_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (bus.cmd_valid_i) begin
          cyc_d   = 1'b1;
          we_d    = bus.cmd_we_i;
          sel_d   = bus.cmd_sel_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          state_d = ST_BUS;
        end
      end
      (state_q == ST_BUS): begin
        // Ack takes priority over a timeout on the same edge.
        if (bus.wbm_ack_i || expired) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          adr_d   = '0;
          dat_d   = '0;
          rv_d    = 1'b1;
          re_d    = !bus.wbm_ack_i;
          rd_d    = (bus.wbm_ack_i && !we_q)
                  ? bus.wbm_dat_i : '0;
          state_d = ST_RESP;
        end
      end
      (state_q == ST_RESP): begin
        if (bus.rsp_ready_i) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = '0;
        adr_d   = '0;
        dat_d   = '0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
    end
  end

  // Gated by reset so nothing looks acceptable while held.
  assign bus.cmd_ready_o = (state_q == ST_IDLE) && wb_rst_i;

  assign bus.rsp_valid_o = rv_q;
  assign bus.rsp_dat_o   = rd_q;
  assign bus.rsp_err_o   = re_q;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;

  assign bus.busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed and random commands,
// checked against a cycle-count model of the WB transaction.
module tb_wb_cmd_master;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.AW(32), .DW(32)) bus ();

  wb_cmd_master #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: ack arrives dly cycles after stb rises (0 = first
  // cycle). No ack within TO cycles means a timeout abort.
  task automatic run_cmd(input logic we,
                         input logic [31:0] adr,
                         input logic [31:0] dat,
                         input logic [3:0] sel,
                         input int dly,
                         input logic [31:0] rdat,
                         input int rdy_wait,
                         input bit hold);
    int exp_cyc;
    logic exp_err;
    logic [31:0] exp_dat;
    int c;
    logic stable;
    exp_cyc = (dly < TO) ? dly + 1 : TO;
    exp_err = (dly >= TO);
    exp_dat = (exp_err || we) ? 32'h0 : rdat;
    chk("cmd_ready_idle", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i   = 32'h0;
    bus.cmd_dat_i   = 32'h0;
    stable = 1'b1;
    c = 0;
    while (bus.wbm_cyc_o === 1'b1 && c < 20) begin
      if (bus.wbm_stb_o !== 1'b1 ||
          bus.wbm_adr_o !== adr ||
          bus.wbm_dat_o !== dat ||
          bus.wbm_sel_o !== sel ||
          bus.wbm_we_o  !== we)
        stable = 1'b0;
      bus.wbm_dat_i = rdat;
      bus.wbm_ack_i = (c == dly);
      tick();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = $urandom;
      c++;
    end
    chk("cyc_len", 64'(c), 64'(exp_cyc));
    chk("bus_stable", stable, 1);
    chk("rsp_valid", bus.rsp_valid_o, 1);
    chk("rsp_err", bus.rsp_err_o, exp_err);
    chk("rsp_dat", bus.rsp_dat_o, exp_dat);
    chk("wbm_cleared",
        {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
         bus.wbm_adr_o, bus.wbm_dat_o}, 0);
    chk("cmd_ready_resp", bus.cmd_ready_o, 0);
    if (!hold) begin
      repeat (rdy_wait) tick();
      if (rdy_wait > 0) begin
        chk("rsp_held_valid", bus.rsp_valid_o, 1);
        chk("rsp_held_dat", bus.rsp_dat_o, exp_dat);
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      chk("rsp_done", bus.rsp_valid_o, 0);
      chk("rsp_dat_kept", bus.rsp_dat_o, exp_dat);
      chk("ready_again", bus.cmd_ready_o, 1);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_sel_i   = 4'hF;
    bus.cmd_adr_i   = 32'h3000_0004;
    bus.cmd_dat_i   = 32'h1234_5678;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_dat_i   = 32'h0;
    bus.wbm_ack_i   = 1'b0;

    // Reset held with a command offered.
    repeat (3) tick();
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    chk("rst_stb", bus.wbm_stb_o, 0);
    chk("rst_wbm",
        {bus.wbm_we_o, bus.wbm_sel_o,
         bus.wbm_adr_o, bus.wbm_dat_o}, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp",
        {bus.rsp_err_o, bus.rsp_dat_o}, 0);
    chk("rst_cmd_ready", bus.cmd_ready_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    bus.cmd_valid_i = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", bus.cmd_ready_o, 1);
    tick();

    // Directed write: ack on second cycle of stb.
    run_cmd(1'b1, 32'h3000_0000, 32'h0000_00FF, 4'hF,
            1, 32'hDEAD_BEEF, 0, 1'b0);
    // Directed read: ack in first cycle.
    run_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF,
            0, 32'h0000_00FF, 0, 1'b0);
    // Timeout: no ack at all.
    run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF,
            99, 32'hCAFE_0001, 1, 1'b0);
    // Ack on the last allowed cycle wins.
    run_cmd(1'b0, 32'h3000_000C, 32'h0, 4'h3,
            TO - 1, 32'hA5A5_5A5A, 0, 1'b0);
    // Write timing out.
    run_cmd(1'b1, 32'h3000_0010, 32'h55, 4'h1,
            TO, 32'h0, 2, 1'b0);

    // Backpressure with a new command pending.
    run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF,
            0, 32'h0BAD_F00D, 0, 1'b1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_adr_i   = 32'h3000_0024;
    bus.cmd_dat_i   = 32'h7777_0001;
    bus.cmd_sel_i   = 4'hC;
    repeat (5) begin
      tick();
      chk("bp_valid", bus.rsp_valid_o, 1);
      chk("bp_dat", bus.rsp_dat_o, 32'h0BAD_F00D);
      chk("bp_err", bus.rsp_err_o, 0);
      chk("bp_ready", bus.cmd_ready_o, 0);
      chk("bp_cyc", bus.wbm_cyc_o, 0);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("bp_rsp_done", bus.rsp_valid_o, 0);
    chk("bp_ready_back", bus.cmd_ready_o, 1);
    chk("bp_no_cyc_yet", bus.wbm_cyc_o, 0);
    tick();
    bus.cmd_valid_i = 1'b0;
    chk("bp_next_cyc", bus.wbm_cyc_o, 1);
    chk("bp_next_adr", bus.wbm_adr_o, 32'h3000_0024);
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    chk("bp_next_rsp", bus.rsp_valid_o, 1);
    chk("bp_next_dat", bus.rsp_dat_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // Random commands.
    for (int i = 0; i < 24; i++) begin
      run_cmd(1'($urandom_range(0, 1)),
              $urandom, $urandom,
              4'($urandom_range(0, 15)),
              $urandom_range(0, TO + 2),
              $urandom,
              $urandom_range(0, 3), 1'b0);
    end

    // Ack while idle must be ignored.
    bus.wbm_ack_i = 1'b1;
    repeat (3) tick();
    bus.wbm_ack_i = 1'b0;
    chk("idle_ack_busy", bus.busy_o, 0);
    chk("idle_ack_rsp", bus.rsp_valid_o, 0);
    chk("idle_ack_cyc", bus.wbm_cyc_o, 0);

    // Async reset in the middle of a bus cycle.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h3000_0030;
    tick();
    bus.cmd_valid_i = 1'b0;
    chk("ar_cyc_up", bus.wbm_cyc_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc", bus.wbm_cyc_o, 0);
    chk("ar_stb", bus.wbm_stb_o, 0);
    chk("ar_busy", bus.busy_o, 0);
    bus.wbm_ack_i = 1'b1;
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    bus.wbm_ack_i = 1'b0;
    chk("ar_late_ack", bus.rsp_valid_o, 0);
    chk("ar_idle", bus.busy_o, 0);
    chk("ar_ready", bus.cmd_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
